// File: rtl/branch_redirect_unit.sv
// branch_redirect_unit: oldest-mispredict fetch redirect/flush plus predictor-update FIFO
module branch_redirect_unit #(
  parameter int ROB_W       = 6,
  parameter int UPD_DEPTH   = 8,
  parameter int RECOVER_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [63:0]      br_pc_i,
  input  logic [ROB_W-1:0] br_rob_tag_i,
  input  logic             br_taken_i,
  input  logic [63:0]      br_target_i,
  input  logic             br_mispredict_i,
  input  logic [ROB_W-1:0] rob_head_tag_i,
  input  logic             ext_flush_i,
  output logic             redirect_valid_o,
  output logic [63:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [ROB_W-1:0] flush_rob_tag_o,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [63:0]      upd_pc_o,
  output logic             upd_taken_o,
  output logic [63:0]      upd_target_o,
  output logic             upd_mispredict_o,
  output logic [31:0]      mispred_cnt_o
);
  localparam int AW = $clog2(UPD_DEPTH);
  localparam int CW = $clog2(RECOVER_CYC) + 1;
  typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic pend_valid, pend_valid_d;
  logic [ROB_W-1:0] pend_tag, pend_tag_d, age_in, age_pend;
  logic [63:0] rpc, rpc_d;
  logic [129:0] mem [UPD_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic squashed, accept, acc_mis, full, empty, deq;
  assign age_in = br_rob_tag_i - rob_head_tag_i;
  assign age_pend = pend_tag - rob_head_tag_i;
  assign squashed = pend_valid & (age_in > age_pend);
  assign full = count == (AW+1)'(UPD_DEPTH);
  assign empty = count == '0;
  assign br_ready_o = !full;
  assign accept = br_valid_i & !full & !ext_flush_i & !squashed;
  assign acc_mis = accept & br_mispredict_i;
  assign deq = !empty & upd_ready_i;
  assign upd_valid_o = !empty;
  assign {upd_pc_o, upd_taken_o, upd_target_o, upd_mispredict_o} = empty ? '0 : mem[rd_ptr];
  assign redirect_valid_o = state == REDIRECT;
  assign flush_o = state == REDIRECT;
  assign redirect_pc_o = rpc;
  assign flush_rob_tag_o = pend_tag;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    pend_valid_d = pend_valid;
    pend_tag_d = pend_tag;
    rpc_d = rpc;
    if (ext_flush_i) begin
      state_d = IDLE;
      pend_valid_d = 1'b0;
    end else if (acc_mis) begin
      state_d = REDIRECT;
      pend_valid_d = 1'b1;
      pend_tag_d = br_rob_tag_i;
      rpc_d = br_target_i;
    end else if (state == REDIRECT) begin
      state_d = DRAIN;
      cnt_d = CW'(RECOVER_CYC - 1);
    end else if (state == DRAIN) begin
      state_d = cnt == '0 ? IDLE : DRAIN;
      pend_valid_d = cnt != '0;
      cnt_d = cnt == '0 ? '0 : cnt - 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      pend_valid <= 1'b0;
      pend_tag <= '0;
      rpc <= '0;
      mispred_cnt_o <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      pend_valid <= pend_valid_d;
      pend_tag <= pend_tag_d;
      rpc <= rpc_d;
      mispred_cnt_o <= mispred_cnt_o + {31'd0, acc_mis};
      wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, accept};
      rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, deq};
      count <= count + (AW+1)'(accept) - (AW+1)'(deq);
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= {br_pc_i, br_taken_i, br_target_i, br_mispredict_i};
  end
endmodule
